// File: rtl/cadence_pkg.sv
// Shared types and constants for the cadence sensor emulator.
// The BNC_R/BNC_F states exist only when CADENCE_BOUNCE_EN is defined.
package cadence_pkg;

   localparam int PERIOD_W_DEF   = 24;
   localparam int BOUNCE_W_DEF   = 8;
   localparam int BOUNCE_CNT_DEF = 3;

   // Debounce window of the downstream filter in fast-sim builds; keep bounce_len well below it.
   localparam int DEBOUNCE_WIN   = 512;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
`ifdef CADENCE_BOUNCE_EN
      BNC_R = 3'd1,
      BNC_F = 3'd3,
`endif
      HIGH  = 3'd2,
      LOW   = 3'd4
   } cad_state_t;

endpackage

// File: rtl/cadence_phase_cnt.sv
// Loadable down-counter that stops at zero; zero marks the last cycle of a phase or segment.
module cadence_phase_cnt #(
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] val,
   output logic         zero
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         val <= '0;
      end else if (load) begin
         val <= load_val;
      end else if (val != '0) begin
         val <= val - W'(1);
      end
   end

   assign zero = (val == '0);

endmodule

// File: rtl/cadence_gen.sv
// Pedal-cadence sensor emulator: square wave with programmable half-period.
// Define CADENCE_BOUNCE_EN to inject contact bounce at every edge.
module cadence_gen
   import cadence_pkg::*;
#(
   parameter int PERIOD_W   = PERIOD_W_DEF,
   parameter int BOUNCE_CNT = BOUNCE_CNT_DEF,
   parameter int BOUNCE_W   = BOUNCE_W_DEF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [PERIOD_W-1:0] half_per,
   input  logic [BOUNCE_W-1:0] bounce_len,
   output logic                cadence,
   output logic                cadence_rise,
   output logic                busy
);

   cad_state_t          state_q, state_d;
   logic [PERIOD_W-1:0] hp_q, hp_new, ph_val_d, ph_val_unused;
   logic                ph_load, ph_zero;
   logic                cadence_d, rise_d, latch;
   logic                start_rise, start_fall;

   assign hp_new = (half_per == '0) ? PERIOD_W'(1) : half_per;
   assign busy   = (state_q != IDLE);

   cadence_phase_cnt #(.W(PERIOD_W)) u_phase (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (ph_load),
      .load_val (ph_val_d),
      .val      (ph_val_unused),
      .zero     (ph_zero)
   );

`ifdef CADENCE_BOUNCE_EN
   localparam int SEG_N  = 2 * BOUNCE_CNT;
   localparam int SEG_IW = $clog2(SEG_N + 1);

   logic [BOUNCE_W-1:0] bl_q, seg_val_d, seg_val_unused;
   logic                seg_load, seg_zero;
   logic [SEG_IW-1:0]   seg_idx_q, seg_idx_d;

   cadence_phase_cnt #(.W(BOUNCE_W)) u_segment (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (seg_load),
      .load_val (seg_val_d),
      .val      (seg_val_unused),
      .zero     (seg_zero)
   );
`else
   localparam int unused_bounce_cnt = BOUNCE_CNT;
   logic unused_bounce;
   assign unused_bounce = ^bounce_len;
`endif

   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      cadence_d  = cadence;
      rise_d     = 1'b0;
      latch      = 1'b0;
      ph_load    = 1'b0;
      ph_val_d   = hp_q - PERIOD_W'(1);
      start_rise = 1'b0;
      start_fall = 1'b0;
`ifdef CADENCE_BOUNCE_EN
      seg_load   = 1'b0;
      seg_val_d  = bl_q - BOUNCE_W'(1);
      seg_idx_d  = seg_idx_q;
`endif
      case (state_q)
         IDLE: if (en) start_rise = 1'b1;
         HIGH: if (ph_zero) start_fall = 1'b1;
         LOW: begin
            if (ph_zero) begin
               if (en) begin
                  start_rise = 1'b1;
               end else begin
                  state_d   = IDLE;
                  cadence_d = 1'b0;
               end
            end
         end
`ifdef CADENCE_BOUNCE_EN
         BNC_R, BNC_F: begin
            if (seg_zero) begin
               if (seg_idx_q == SEG_IW'(SEG_N - 1)) begin
                  state_d   = (state_q == BNC_R) ? HIGH : LOW;
                  cadence_d = (state_q == BNC_R);
                  ph_load   = 1'b1;
               end else begin
                  seg_idx_d = seg_idx_q + SEG_IW'(1);
                  seg_load  = 1'b1;
                  cadence_d = ~cadence;
               end
            end
         end
`endif
         default: begin
            state_d   = IDLE;
            cadence_d = 1'b0;
         end
      endcase

      // New edges are decided after the per-state logic so both entry points share one path.
      if (start_rise) begin
         latch     = 1'b1;
         rise_d    = 1'b1;
         cadence_d = 1'b1;
`ifdef CADENCE_BOUNCE_EN
         if (bounce_len != '0) begin
            state_d   = BNC_R;
            seg_load  = 1'b1;
            seg_val_d = bounce_len - BOUNCE_W'(1);
            seg_idx_d = '0;
         end else begin
            state_d  = HIGH;
            ph_load  = 1'b1;
            ph_val_d = hp_new - PERIOD_W'(1);
         end
`else
         state_d  = HIGH;
         ph_load  = 1'b1;
         ph_val_d = hp_new - PERIOD_W'(1);
`endif
      end

      if (start_fall) begin
         cadence_d = 1'b0;
`ifdef CADENCE_BOUNCE_EN
         if (bl_q != '0) begin
            state_d   = BNC_F;
            seg_load  = 1'b1;
            seg_idx_d = '0;
         end else begin
            state_d = LOW;
            ph_load = 1'b1;
         end
`else
         state_d = LOW;
         ph_load = 1'b1;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         cadence      <= 1'b0;
         cadence_rise <= 1'b0;
         hp_q         <= '0;
      end else begin
         state_q      <= state_d;
         cadence      <= cadence_d;
         cadence_rise <= rise_d;
         if (latch) hp_q <= hp_new;
      end
   end

`ifdef CADENCE_BOUNCE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bl_q      <= '0;
         seg_idx_q <= '0;
      end else begin
         seg_idx_q <= seg_idx_d;
         if (latch) bl_q <= bounce_len;
      end
   end
`endif

endmodule

// File: tb/tb_cadence_gen.sv
// Self-checking bench for cadence_gen: per-cycle schedule model plus directed literal windows.
// Covers the CADENCE_BOUNCE_EN build when that macro is defined.
module tb_cadence_gen;
   import cadence_pkg::*;

   localparam int PW  = 24;
   localparam int BW  = 8;
   localparam int BNC = 3;
`ifdef CADENCE_BOUNCE_EN
   localparam bit BOUNCE_BUILD = 1'b1;
`else
   localparam bit BOUNCE_BUILD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic [PW-1:0] half_per = '0;
   logic [BW-1:0] bounce_len = '0;
   logic          cadence, cadence_rise, busy;

   int vectors = 0;
   int miscompares = 0;
   bit run_chk = 1'b0;

   cadence_gen #(.PERIOD_W(PW), .BOUNCE_CNT(BNC), .BOUNCE_W(BW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .en           (en),
      .half_per     (half_per),
      .bounce_len   (bounce_len),
      .cadence      (cadence),
      .cadence_rise (cadence_rise),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a whole period is laid out as a list of per-cycle output levels
   // when it starts; the next period may start only once that list is used up.
   typedef struct packed {
      logic cad;
      logic rise;
   } slot_t;

   slot_t sched[$];
   logic  exp_cad = 1'b0, exp_rise = 1'b0, exp_busy = 1'b0;

   task automatic build_period(input int unsigned hp_in, input int unsigned bl);
      int unsigned hp = (hp_in == 0) ? 1 : hp_in;
      int unsigned bl_eff = BOUNCE_BUILD ? bl : 0;
      bit first = 1'b1;
      slot_t s;
      for (int lvl = 1; lvl >= 0; lvl--) begin
         for (int k = 0; k < 2 * BNC; k++) begin
            for (int unsigned c = 0; c < bl_eff; c++) begin
               s.cad  = (k % 2 == 0) ? lvl[0] : ~lvl[0];
               s.rise = first;
               first  = 1'b0;
               sched.push_back(s);
            end
         end
         for (int unsigned c = 0; c < hp; c++) begin
            s.cad  = lvl[0];
            s.rise = first;
            first  = 1'b0;
            sched.push_back(s);
         end
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sched.delete();
         exp_cad  = 1'b0;
         exp_rise = 1'b0;
         exp_busy = 1'b0;
      end else begin
         slot_t s;
         if (sched.size() == 0 && en) build_period(half_per, bounce_len);
         if (sched.size() != 0) begin
            s        = sched.pop_front();
            exp_cad  = s.cad;
            exp_rise = s.rise;
            exp_busy = 1'b1;
         end else begin
            exp_cad  = 1'b0;
            exp_rise = 1'b0;
            exp_busy = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && run_chk) begin
         check("model_cadence", cadence, exp_cad);
         check("model_rise", cadence_rise, exp_rise);
         check("model_busy", busy, exp_busy);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic grab(input int n, output logic [63:0] w_cad, output logic [63:0] w_rise);
      w_cad  = '0;
      w_rise = '0;
      for (int i = 0; i < n; i++) begin
         step();
         w_cad  = {w_cad[62:0], cadence};
         w_rise = {w_rise[62:0], cadence_rise};
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 5000) begin
         step();
         n++;
      end
      check("wait_idle_busy", busy, 0);
   endtask

   initial begin : stim
      logic [63:0] wc, wr;

      #22 rst_n = 1'b1;
      run_chk = 1'b1;
      step();
      step();
      check("reset_cadence", cadence, 0);
      check("reset_rise", cadence_rise, 0);
      check("reset_busy", busy, 0);

      // Basic run at half_per=4.
      en = 1'b1;
      half_per = 24'd4;
      bounce_len = '0;
      grab(16, wc, wr);
      check("hp4_pattern", wc, 64'h0000_0000_0000_F0F0);
      check("hp4_rise", wr, 64'h0000_0000_0000_8080);
      check("hp4_busy", busy, 1);

      // half_per changed during HIGH only affects the following period.
      step();
      half_per = 24'd10;
      grab(27, wc, wr);
      check("hp_change", wc, 64'({3'b111, 4'b0000, 10'h3ff, 10'h000}));
      check("hp_change_rise", wr, 64'({3'b000, 4'b0000, 10'h200, 10'h000}));

      // en dropped in the second HIGH cycle: period completes, then idle.
      half_per = 24'd6;
      step();
      step();
      en = 1'b0;
      grab(14, wc, wr);
      check("en_drop", wc, 64'(14'b1111_000000_0000));
      check("en_drop_busy", busy, 0);

      // half_per=0 behaves as 1.
      en = 1'b1;
      half_per = '0;
      grab(8, wc, wr);
      check("hp0_pattern", wc, 64'h0000_0000_0000_00AA);
      check("hp0_rise", wr, 64'h0000_0000_0000_00AA);

      // Asynchronous reset in the middle of HIGH.
      half_per = 24'd5;
      step();
      step();
      #3 rst_n = 1'b0;
      en = 1'b0;
      #1;
      check("arst_cadence", cadence, 0);
      check("arst_rise", cadence_rise, 0);
      check("arst_busy", busy, 0);
      #12 rst_n = 1'b1;
      step();
      en = 1'b1;
      grab(10, wc, wr);
      check("restart_pattern", wc, 64'(10'b11111_00000));
      check("restart_rise", wr, 64'(10'b10000_00000));

`ifdef CADENCE_BOUNCE_EN
      begin : bounce_test
         int rises = 0, filt_rises = 0, stable = 0;
         logic last = 1'b0, filt = 1'b0;
         logic [5:0] seg_lv = '0;
         en = 1'b0;
         wait_idle();
         half_per = 24'd1000;
         bounce_len = 8'd20;
         en = 1'b1;
         for (int i = 0; i < 4480; i++) begin
            step();
            if (i < 120 && i % 20 == 0) seg_lv = {seg_lv[4:0], cadence};
            if (i == 120) check("bnc_high_start", cadence, 1);
            if (cadence_rise) rises++;
            if (cadence == last) stable++;
            else stable = 0;
            last = cadence;
            if (stable >= DEBOUNCE_WIN && filt != cadence) begin
               filt = cadence;
               if (filt) filt_rises++;
            end
         end
         check("bnc_segments", seg_lv, 64'(6'b101010));
         check("bnc_rises", rises, 2);
         check("bnc_filter_rises", filt_rises, 2);
         en = 1'b0;
         bounce_len = '0;
         wait_idle();
      end
`endif

      // Randomised run with an asynchronous reset in the middle.
      for (int i = 0; i < 600; i++) begin
         step();
         en = ($urandom_range(0, 7) != 0);
         half_per = 24'($urandom_range(0, 7));
         bounce_len = 8'($urandom_range(0, 3));
         if (i == 300) begin
            #2 rst_n = 1'b0;
            #1;
            check("rand_arst_cadence", cadence, 0);
            check("rand_arst_busy", busy, 0);
            rst_n = 1'b1;
         end
      end

      en = 1'b0;
      wait_idle();
      step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
